// File: rtl/bitonic_pkg.sv
// Shared types and defaults for the bitonic frame sorter: FSM state encoding,
// default geometry and the padding value used to fill short frames.
package bitonic_pkg;

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    SORT   = 2'd1,
    UNLOAD = 2'd2
  } state_t;

  localparam int DEF_WIDTH       = 8;
  localparam int DEF_INDEX       = 8;
  localparam int DEF_INDEX_WIDTH = 3;
  localparam int DEF_NET_LAT     = 3;

  // All-ones of the given width; sorts after every real value so padding
  // collects at the top of the ascending result.
  function automatic logic [63:0] pad_value(input int width);
    return {64{1'b1}} >> (64 - width);
  endfunction

endpackage

// File: rtl/bitonic_sort_ctrl_net.sv
// Registered bitonic sorting network: each register stage applies one merge
// phase; surplus phases fold into the last stage, surplus stages just delay.
module bitonic_net #(
  parameter int WIDTH       = 8,
  parameter int INDEX       = 8,
  parameter int INDEX_WIDTH = 3,
  parameter int NET_LAT     = 3
) (
  input  logic                   clk,
  input  logic [INDEX*WIDTH-1:0] in_data,
  output logic [INDEX*WIDTH-1:0] out_data
);

  localparam int VW = INDEX * WIDTH;

  logic [VW-1:0] stage_q [NET_LAT];

  function automatic logic [VW-1:0] apply_phases(input logic [VW-1:0] v,
                                                 input int lo, input int hi);
    logic [WIDTH-1:0] a [INDEX];
    logic [WIDTH-1:0] t;
    logic [VW-1:0]    r;
    int               l;
    int               k;
    for (int i = 0; i < INDEX; i++) a[i] = v[i*WIDTH +: WIDTH];
    for (int p = 1; p <= INDEX_WIDTH; p++) begin
      if (p >= lo && p <= hi) begin
        k = 1 << p;
        for (int j = k / 2; j > 0; j = j / 2) begin
          for (int i = 0; i < INDEX; i++) begin
            l = i ^ j;
            if (l > i && (((i & k) == 0) ? (a[i] > a[l]) : (a[i] < a[l]))) begin
              t    = a[i];
              a[i] = a[l];
              a[l] = t;
            end
          end
        end
      end
    end
    r = '0;
    for (int i = 0; i < INDEX; i++) r[i*WIDTH +: WIDTH] = a[i];
    return r;
  endfunction

  for (genvar s = 0; s < NET_LAT; s++) begin : g_stage
    localparam int LO = s + 1;
    localparam int HI = (s == NET_LAT - 1) ? INDEX_WIDTH : s + 1;
    logic [VW-1:0] stage_in;
    if (s == 0) begin : g_first
      assign stage_in = in_data;
    end else begin : g_next
      assign stage_in = stage_q[s-1];
    end
    // NOTE: pure data pipeline with no reset; the controller only samples it
    // after NET_LAT cycles of stable input, which flushes any stale content.
    always_ff @(posedge clk) stage_q[s] <= apply_phases(stage_in, LO, HI);
  end

  assign out_data = stage_q[NET_LAT-1];

endmodule

// File: rtl/bitonic_sort_ctrl.sv
// Frame sorter: loads up to INDEX elements, pads the rest, sorts them through
// the registered bitonic network and streams the real elements out ascending.
module bitonic_sort_ctrl
  import bitonic_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int INDEX       = DEF_INDEX,
  parameter int INDEX_WIDTH = DEF_INDEX_WIDTH,
  parameter int NET_LAT     = DEF_NET_LAT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int                   LAT_W = (NET_LAT < 1) ? 1 : $clog2(NET_LAT + 1);
  localparam logic [WIDTH-1:0]     PAD   = WIDTH'(pad_value(WIDTH));
  localparam logic [INDEX_WIDTH:0] ONE_N = (INDEX_WIDTH + 1)'(1);

  state_t                 state, state_nxt;
  logic [WIDTH-1:0]       frame_buf [INDEX];
  logic [INDEX_WIDTH-1:0] wr_cnt, rd_cnt;
  logic [INDEX_WIDTH:0]   n;
  logic [LAT_W-1:0]       lat_cnt;
  logic [INDEX*WIDTH-1:0] net_in, net_out;
  logic                   in_fire, out_fire, frame_end, sort_done, unload_done;

  assign in_fire     = in_valid && in_ready;
  assign out_fire    = out_valid && out_ready;
  assign frame_end   = in_fire && (in_last || wr_cnt == INDEX_WIDTH'(INDEX - 1));
  assign sort_done   = (state == SORT) && (lat_cnt == LAT_W'(NET_LAT));
  assign unload_done = out_fire && out_last;

  // NOTE: sequential state uses <= so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: default assignment first keeps this block free of inferred latches.
    state_nxt = state;
    case (state)
      LOAD:    if (frame_end)   state_nxt = SORT;
      SORT:    if (sort_done)   state_nxt = UNLOAD;
      UNLOAD:  if (unload_done) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  // Outputs are forced low combinationally while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b0;
    if (!rst) begin
      in_ready  = (state == LOAD);
      out_valid = (state == UNLOAD);
      busy      = (state != LOAD) || (wr_cnt != '0);
      if (state == UNLOAD) begin
        out_data = frame_buf[rd_cnt];
        out_last = ({1'b0, rd_cnt} == n - ONE_N);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      lat_cnt <= '0;
      n       <= '0;
      for (int i = 0; i < INDEX; i++) frame_buf[i] <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            frame_buf[wr_cnt] <= in_data;
            wr_cnt            <= wr_cnt + INDEX_WIDTH'(1);
          end
          if (frame_end) begin
            n       <= {1'b0, wr_cnt} + ONE_N;
            lat_cnt <= '0;
            for (int i = 0; i < INDEX; i++)
              if (i > int'(wr_cnt)) frame_buf[i] <= PAD;
          end
        end
        SORT: begin
          if (sort_done) begin
            lat_cnt <= '0;
            for (int i = 0; i < INDEX; i++) frame_buf[i] <= net_out[i*WIDTH +: WIDTH];
          end else begin
            lat_cnt <= lat_cnt + LAT_W'(1);
          end
        end
        UNLOAD: begin
          if (out_fire) begin
            if (out_last) begin
              rd_cnt <= '0;
              wr_cnt <= '0;
            end else begin
              rd_cnt <= rd_cnt + INDEX_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    net_in = '0;
    for (int i = 0; i < INDEX; i++) net_in[i*WIDTH +: WIDTH] = frame_buf[i];
  end

  bitonic_net #(
    .WIDTH       (WIDTH),
    .INDEX       (INDEX),
    .INDEX_WIDTH (INDEX_WIDTH),
    .NET_LAT     (NET_LAT)
  ) u_net (
    .clk      (clk),
    .in_data  (net_in),
    .out_data (net_out)
  );

endmodule

// File: tb/tb_bitonic_sort_ctrl.sv
// Scoreboard bench for bitonic_sort_ctrl: directed frames push hand-sorted
// expectations; an independent monitor checks every presented output.
module tb_bitonic_sort_ctrl;

  localparam int WIDTH       = 8;
  localparam int INDEX       = 8;
  localparam int INDEX_WIDTH = 3;
  localparam int NET_LAT     = 3;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             busy;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             last;
  } exp_t;

  exp_t             sb [$];
  int               checks = 0;
  int               errors = 0;
  logic [WIDTH-1:0] frame [INDEX];
  logic [WIDTH-1:0] expv  [INDEX];
  bit               toggle_en  = 1'b0;
  bit               hold_valid = 1'b0;

  always #5 clk = ~clk;

  bitonic_sort_ctrl #(
    .WIDTH       (WIDTH),
    .INDEX       (INDEX),
    .INDEX_WIDTH (INDEX_WIDTH),
    .NET_LAT     (NET_LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input int len);
    for (int i = 0; i < len; i++) sb.push_back('{data: expv[i], last: (i == len - 1)});
  endtask

  // Called at a negedge; each element is handed over at the following posedge.
  task automatic send_frame(input int len);
    for (int i = 0; i < len; i++) begin
      int guard = 0;
      in_valid = 1'b1;
      in_data  = frame[i];
      in_last  = (i == len - 1);
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (!in_ready) check("in_ready_timeout", in_ready, 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Entered one cycle after the final input handshake.
  task automatic check_latency(input string name);
    int cnt = 1;
    while (!out_valid && cnt < 30) begin
      check({name, "_in_ready_low"}, in_ready, 0);
      @(negedge clk);
      cnt++;
    end
    check({name, "_latency"}, cnt, NET_LAT + 2);
  endtask

  task automatic drain(input string name);
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check({name, "_drained"}, sb.size(), 0);
    check({name, "_in_ready_after"}, in_ready, 1);
    check({name, "_busy_after"}, busy, 0);
  endtask

  // Monitor: compares every presented element against the scoreboard head,
  // including stall cycles, and pops only on an accepted handshake.
  initial forever begin
    @(negedge clk);
    #1;
    if (out_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_out_valid", out_valid, 0);
      end else begin
        check("out_data", out_data, sb[0].data);
        check("out_last", out_last, sb[0].last);
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  initial forever begin
    @(negedge clk);
    out_ready = toggle_en ? ~out_ready : 1'b1;
  end

  // Keeps in_valid high with changing data while a frame is in flight.
  initial forever begin
    @(negedge clk);
    if (hold_valid) begin
      if (sb.size() <= 1) begin
        in_valid   = 1'b0;
        in_last    = 1'b0;
        hold_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = WIDTH'($urandom);
        in_last  = 1'($urandom);
        check("hold_in_ready_low", in_ready, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_busy", busy, 0);

    frame = '{8'h05, 8'h03, 8'h07, 8'h01, 8'h08, 8'h02, 8'h06, 8'h04};
    expv  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    push_exp(8);
    send_frame(8);
    check_latency("full");
    drain("full");

    frame = '{8'h09, 8'h02, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expv  = '{8'h02, 8'h05, 8'h09, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_exp(3);
    send_frame(3);
    hold_valid = 1'b1;
    check_latency("partial");
    drain("partial");

    toggle_en = 1'b1;
    frame = '{8'h05, 8'h03, 8'h07, 8'h01, 8'h08, 8'h02, 8'h06, 8'h04};
    expv  = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    push_exp(8);
    send_frame(8);
    check_latency("stall");
    drain("stall");
    toggle_en = 1'b0;

    frame = '{8'hFF, 8'h00, 8'hFF, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'hFF};
    expv  = '{8'h00, 8'h00, 8'h01, 8'h7F, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    push_exp(8);
    send_frame(8);
    check_latency("pad_data");
    drain("pad_data");

    frame = '{8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expv  = '{8'h42, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_exp(1);
    send_frame(1);
    check_latency("single");
    drain("single");

    // Reset while the third sorted element is on the output.
    frame = '{8'h05, 8'h03, 8'h07, 8'h01, 8'h08, 8'h02, 8'h06, 8'h04};
    sb.push_back('{data: 8'h01, last: 1'b0});
    sb.push_back('{data: 8'h02, last: 1'b0});
    send_frame(8);
    begin
      int guard = 0;
      while (sb.size() != 0 && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      check("abort_two_emitted", sb.size(), 0);
    end
    rst = 1'b1;
    #2;
    check("abort_rst_out_valid", out_valid, 0);
    @(negedge clk);
    check("abort_next_out_valid", out_valid, 0);
    check("abort_next_in_ready", in_ready, 0);
    rst = 1'b0;
    #2;
    check("abort_release_in_ready", in_ready, 1);
    check("abort_release_out_valid", out_valid, 0);
    check("abort_release_busy", busy, 0);

    frame = '{8'h04, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    expv  = '{8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    push_exp(2);
    send_frame(2);
    check_latency("after_abort");
    drain("after_abort");

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
